// File: rtl/lock_sequencer_if.sv
// Keypad/lock signal bundle: keypad and pushbutton inputs toward the sequencer, registered status outputs back.
// master drives keys and the lock button; slave is the sequencer.
interface lock_sequencer_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        lock_button;
   logic [3:0]  pass_signal;
   logic [2:0]  press_count;
   logic [15:0] state_led;

   modport master (
      output key_valid, key_code, lock_button,
      input  pass_signal, press_count, state_led
   );

   modport slave (
      input  key_valid, key_code, lock_button,
      output pass_signal, press_count, state_led
   );
endinterface

// File: rtl/lock_sequencer.sv
// Four-digit keypad lock with fail counting and timed lockout; outputs registered, updated on the edge that moves the FSM.
// No backpressure: keys arriving in CHECK/UNLOCKED/FAIL/LOCKOUT are dropped.
module lock_sequencer #(
   parameter logic [15:0] PASSCODE       = 16'h1234,
   parameter int unsigned FAIL_CYCLES    = 100_000_000,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000,
   parameter int unsigned ENTRY_TIMEOUT  = 500_000_000,
   parameter int unsigned RELOCK_CYCLES  = 0
) (
   input logic            clk,
   input logic            reset,
   lock_sequencer_if.slave bus
);

   localparam int unsigned MAX_A = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned MAX_B = (ENTRY_TIMEOUT > RELOCK_CYCLES) ? ENTRY_TIMEOUT : RELOCK_CYCLES;
   localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   // The timer holds load values up to MAX_T-1, so $clog2(MAX_T) bits suffice.
   localparam int TW = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [TW-1:0] FAIL_LD   = TW'((FAIL_CYCLES    > 0) ? FAIL_CYCLES    - 1 : 0);
   localparam logic [TW-1:0] LOCK_LD   = TW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
   localparam logic [TW-1:0] ENTRY_LD  = TW'((ENTRY_TIMEOUT  > 0) ? ENTRY_TIMEOUT  - 1 : 0);
   localparam logic [TW-1:0] RELOCK_LD = TW'((RELOCK_CYCLES  > 0) ? RELOCK_CYCLES  - 1 : 0);
   localparam bit            RELOCK_EN = (RELOCK_CYCLES != 0);
   localparam logic [2:0]    FAIL_LIM  = 3'(MAX_FAILS);

   typedef enum logic [2:0] {
      IDLE, ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT
   } state_t;

   state_t        state_q, state_n;
   logic [15:0]   entry_q, entry_n;
   logic [2:0]    count_q, count_n;
   logic [2:0]    fails_q, fails_n;
   logic [TW-1:0] timer_q, timer_n;
   logic          lock_prev_q;
   logic [3:0]    pass_q;
   logic [15:0]   led_q;

   logic          is_digit, is_clear, lock_rise, timer_zero;
   logic [TW-1:0] timer_dec;

   assign is_digit   = bus.key_valid && (bus.key_code <= 4'hD);
   assign is_clear   = bus.key_valid && (bus.key_code == 4'hE);
   assign lock_rise  = bus.lock_button && !lock_prev_q;
   assign timer_zero = (timer_q == '0);
   assign timer_dec  = timer_zero ? timer_q : timer_q - TW'(1);

   function automatic logic [3:0] pass_of(input state_t s);
      case (s)
         UNLOCKED: return 4'b0010;
         FAIL:     return 4'b0100;
         LOCKOUT:  return 4'b1000;
         default:  return 4'b0001;
      endcase
   endfunction

   always_comb begin
      state_n = state_q;
      entry_n = entry_q;
      count_n = count_q;
      fails_n = fails_q;
      timer_n = timer_q;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               state_n = ENTRY;
               entry_n = {entry_q[11:0], bus.key_code};
               count_n = 3'd1;
               timer_n = ENTRY_LD;
            end
         end
         ENTRY: begin
            if (lock_rise || is_clear) begin
               state_n = IDLE;
               entry_n = '0;
               count_n = '0;
               timer_n = '0;
            end else if (bus.key_valid) begin
               // Any key restarts the idle timer, even one that lands on the expiry cycle.
               timer_n = ENTRY_LD;
               if (is_digit) begin
                  entry_n = {entry_q[11:0], bus.key_code};
                  count_n = count_q + 3'd1;
                  if (count_q == 3'd3) begin
                     state_n = CHECK;
                     timer_n = '0;
                  end
               end
            end else if (timer_zero) begin
               state_n = IDLE;
               entry_n = '0;
               count_n = '0;
            end else begin
               timer_n = timer_dec;
            end
         end
         CHECK: begin
            entry_n = '0;
            count_n = '0;
            if (entry_q == PASSCODE) begin
               state_n = UNLOCKED;
               fails_n = '0;
               timer_n = RELOCK_LD;
            end else begin
               state_n = FAIL;
               fails_n = (fails_q == 3'd7) ? fails_q : fails_q + 3'd1;
               timer_n = FAIL_LD;
            end
         end
         UNLOCKED: begin
            if (lock_rise || (RELOCK_EN && timer_zero)) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer_dec;
            end
         end
         FAIL: begin
            if (timer_zero) begin
               if (fails_q >= FAIL_LIM) begin
                  state_n = LOCKOUT;
                  timer_n = LOCK_LD;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               timer_n = timer_dec;
            end
         end
         LOCKOUT: begin
            if (timer_zero) begin
               state_n = IDLE;
               fails_n = '0;
            end else begin
               timer_n = timer_dec;
            end
         end
         default: begin
            state_n = IDLE;
            entry_n = '0;
            count_n = '0;
            timer_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         entry_q     <= '0;
         count_q     <= '0;
         fails_q     <= '0;
         timer_q     <= '0;
         lock_prev_q <= 1'b0;
         pass_q      <= 4'b0001;
         led_q       <= 16'h0001;
      end else begin
         state_q     <= state_n;
         entry_q     <= entry_n;
         count_q     <= count_n;
         fails_q     <= fails_n;
         timer_q     <= timer_n;
         lock_prev_q <= bus.lock_button;
         pass_q      <= pass_of(state_n);
         led_q       <= {7'd0, fails_n, 6'b000001 << state_n};
      end
   end

   assign bus.pass_signal = pass_q;
   assign bus.press_count = count_q;
   assign bus.state_led   = led_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench: stimulus queues the expected outputs per cycle, a negedge monitor pops and compares.
module tb_lock_sequencer;

   localparam int ST_I = 0, ST_E = 1, ST_C = 2, ST_U = 3, ST_F = 4, ST_L = 5;

   logic clk = 1'b0;
   logic reset;
   lock_sequencer_if bus();

   lock_sequencer #(
      .PASSCODE(16'h1234), .FAIL_CYCLES(4), .MAX_FAILS(2),
      .LOCKOUT_CYCLES(8), .ENTRY_TIMEOUT(6), .RELOCK_CYCLES(0)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  pass;
      logic [2:0]  cnt;
      logic [15:0] led;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] pass_of(input int st);
      case (st)
         ST_U:    return 4'b0010;
         ST_F:    return 4'b0100;
         ST_L:    return 4'b1000;
         default: return 4'b0001;
      endcase
   endfunction

   function automatic logic [15:0] led_of(input int st, input int fl);
      return 16'((fl << 6) | (1 << st));
   endfunction

   // Drive one cycle of inputs and queue what the outputs must be after the coming edge.
   task automatic tick(input logic kv, input logic [3:0] kc, input logic lb, input logic rs,
                       input int st, input int cnt, input int fl, input string nm);
      exp_t e;
      bus.key_valid   = kv;
      bus.key_code    = kc;
      bus.lock_button = lb;
      reset           = rs;
      e.cyc  = cyc + 1;
      e.pass = pass_of(st);
      e.cnt  = 3'(cnt);
      e.led  = led_of(st, fl);
      e.nm   = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input int st, input int cnt, input int fl, input string nm);
      for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0, 1'b0, st, cnt, fl, nm);
   endtask

   task automatic enter4(input logic [15:0] code, input int fl, input string nm);
      tick(1'b1, code[15:12], 1'b0, 1'b0, ST_E, 1, fl, nm);
      tick(1'b1, code[11:8],  1'b0, 1'b0, ST_E, 2, fl, nm);
      tick(1'b1, code[7:4],   1'b0, 1'b0, ST_E, 3, fl, nm);
      tick(1'b1, code[3:0],   1'b0, 1'b0, ST_C, 4, fl, nm);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.cyc != cyc) begin
               bad++;
               $display("FAIL %s: checked at cycle %0d, due at cycle %0d", e.nm, cyc, e.cyc);
            end else if ({bus.pass_signal, bus.press_count, bus.state_led} !== {e.pass, e.cnt, e.led}) begin
               bad++;
               $display("FAIL %s (cycle %0d): got pass=%b cnt=%0d led=%h, expected pass=%b cnt=%0d led=%h",
                        e.nm, cyc, bus.pass_signal, bus.press_count, bus.state_led, e.pass, e.cnt, e.led);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      tick(1'b0, 4'h0, 1'b0, 1'b1, ST_I, 0, 0, "reset");
      tick(1'b0, 4'h0, 1'b0, 1'b1, ST_I, 0, 0, "reset");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_I, 0, 0, "idle");

      // Correct code, unlock, relock by button edge
      enter4(16'h1234, 0, "good");
      idle(2, ST_U, 0, 0, "unlocked");
      tick(1'b0, 4'h0, 1'b1, 1'b0, ST_I, 0, 0, "relock");
      tick(1'b0, 4'h0, 1'b1, 1'b0, ST_I, 0, 0, "lock_held");
      tick(1'b1, 4'hF, 1'b0, 1'b0, ST_I, 0, 0, "ignore_f");

      // Wrong code: four FAIL cycles, keys dropped, then back to IDLE with one failure
      enter4(16'h1235, 0, "bad1");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_F, 0, 1, "fail");
      tick(1'b1, 4'h7, 1'b0, 1'b0, ST_F, 0, 1, "fail_key");
      idle(2, ST_F, 0, 1, "fail");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_I, 0, 1, "fail_done");

      // Entry timeout keeps the fail count
      tick(1'b1, 4'h1, 1'b0, 1'b0, ST_E, 1, 1, "to_k1");
      tick(1'b1, 4'h2, 1'b0, 1'b0, ST_E, 2, 1, "to_k2");
      idle(5, ST_E, 2, 1, "entry_wait");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_I, 0, 1, "timeout");

      // Key on the expiry cycle wins, then clear key
      tick(1'b1, 4'h1, 1'b0, 1'b0, ST_E, 1, 1, "ex_k1");
      tick(1'b1, 4'h2, 1'b0, 1'b0, ST_E, 2, 1, "ex_k2");
      idle(5, ST_E, 2, 1, "entry_wait2");
      tick(1'b1, 4'h3, 1'b0, 1'b0, ST_E, 3, 1, "key_on_expiry");
      tick(1'b1, 4'hE, 1'b0, 1'b0, ST_I, 0, 1, "clear");

      // Lock button edge abandons entry
      tick(1'b1, 4'h5, 1'b0, 1'b0, ST_E, 1, 1, "lb_k1");
      tick(1'b0, 4'h0, 1'b1, 1'b0, ST_I, 0, 1, "lock_in_entry");

      // Second failure -> lockout for 8 cycles, keys ignored
      enter4(16'h9999, 1, "bad2");
      idle(4, ST_F, 0, 2, "fail2");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_L, 0, 2, "lockout");
      for (int i = 0; i < 7; i++)
         tick(1'(i % 2), 4'h1, 1'b0, 1'b0, ST_L, 0, 2, "lockout_keys");
      tick(1'b1, 4'h1, 1'b0, 1'b0, ST_I, 0, 0, "lockout_done");

      // Entry register unaffected by lockout keys
      enter4(16'h1234, 0, "good2");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_U, 0, 0, "unlock2");
      tick(1'b0, 4'h0, 1'b1, 1'b0, ST_I, 0, 0, "relock2");

      // Reach lockout again and reset in the middle of it
      enter4(16'h0000, 0, "bad3");
      idle(4, ST_F, 0, 1, "fail3");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_I, 0, 1, "fail3_done");
      enter4(16'hABCD, 1, "bad4");
      idle(4, ST_F, 0, 2, "fail4");
      idle(3, ST_L, 0, 2, "lockout2");
      tick(1'b1, 4'h1, 1'b0, 1'b1, ST_I, 0, 0, "reset_lockout");
      tick(1'b1, 4'h1, 1'b0, 1'b0, ST_E, 1, 0, "post_reset");
      tick(1'b1, 4'h2, 1'b0, 1'b1, ST_I, 0, 0, "reset_entry");
      tick(1'b0, 4'h0, 1'b0, 1'b0, ST_I, 0, 0, "post_reset2");

      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
